// File: rtl/pipe_arb.sv
`default_nettype none
// ============================================================================
// Module      : pipe_arb
// Description : Two-requester round-robin arbiter feeding a single registered
//               pipeline stage with stall, flush (one-cycle bubble) and
//               per-requester accepted-operation counters. State advances on
//               the falling edge of clk; reset is asynchronous, active-low.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_arb #(
    parameter int W_OP = 4,
    parameter int W_C  = 3
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    valid0,
    input  logic                    valid1,
    input  logic [W_C-1:0]          cntrl0,
    input  logic [W_C-1:0]          cntrl1,
    input  logic [W_OP-1:0]         a0,
    input  logic [W_OP-1:0]         a1,
    input  logic [W_OP-1:0]         b0,
    input  logic [W_OP-1:0]         b1,
    output logic                    ready0,
    output logic                    ready1,
    input  logic                    stall,
    input  logic                    flush,
    output logic [W_C+2*W_OP-1:0]   out,
    output logic                    out_valid,
    output logic                    out_src,
    output logic [7:0]              cnt0,
    output logic [7:0]              cnt1
);

    localparam int C_W_OUT = W_C + 2 * W_OP;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_HOLD  = 2'd1;
    localparam logic [1:0] c_FLUSH = 2'd2;

    logic [1:0]         r_state;
    logic [C_W_OUT-1:0] r_out;
    logic               r_out_valid;
    logic               r_out_src;
    logic               r_ptr;
    logic [7:0]         r_cnt0;
    logic [7:0]         r_cnt1;

    logic               w_any;
    logic               w_gnt;
    logic               w_en;
    logic               w_acc;
    logic [C_W_OUT-1:0] w_op;

    // Accept enable, round-robin grant and the operation of the granted side.
    // rstn gates the enable so no ready is seen while reset is held.
    always_comb begin
        w_any  = valid0 | valid1;
        w_gnt  = (valid0 && valid1) ? ~r_ptr : valid1;
        w_en   = rstn && !flush &&
                 ((r_state == c_IDLE) || ((r_state == c_HOLD) && !stall));
        w_acc  = w_en && w_any;
        ready0 = w_acc && !w_gnt;
        ready1 = w_acc && w_gnt;
        w_op   = w_gnt ? {cntrl1, a1, b1} : {cntrl0, a0, b0};
    end

    // Pipeline register and control FSM; flush overrides stall and grant.
    always_ff @(negedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= c_IDLE;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_out_src   <= 1'b0;
            r_ptr       <= 1'b1;
        end else if (flush) begin
            r_state     <= c_FLUSH;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE, c_HOLD: begin
                    if (w_acc) begin
                        r_state     <= c_HOLD;
                        r_out       <= w_op;
                        r_out_valid <= 1'b1;
                        r_out_src   <= w_gnt;
                        r_ptr       <= w_gnt;
                    end else if ((r_state == c_HOLD) && !stall) begin
                        // Drained with nothing new: drop valid, keep data.
                        r_state     <= c_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                c_FLUSH: begin
                    r_state     <= c_IDLE;
                    r_out_valid <= 1'b0;
                end
                default: begin
                    r_state     <= c_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Per-requester accept counters; wrap naturally at 8 bits, untouched by flush.
    always_ff @(negedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt0 <= 8'd0;
            r_cnt1 <= 8'd0;
        end else begin
            if (ready0) r_cnt0 <= r_cnt0 + 8'd1;
            if (ready1) r_cnt1 <= r_cnt1 + 8'd1;
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign out_src   = r_out_src;
    assign cnt0      = r_cnt0;
    assign cnt1      = r_cnt1;

endmodule
`default_nettype wire
